// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR control/lfsr/period-checker slice.
package lfsr_pkg;

  localparam int unsigned LFSR_N_DEFAULT = 26;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    DONE,
    FAULT
  } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clr has priority over inc.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = &cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures the recurrence period of an observed LFSR state stream.
// Optional stall fault detection is enabled by defining LFSR_CHK_TIMEOUT_EN.
module lfsr_period_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned N       = LFSR_N_DEFAULT,
  parameter int unsigned CW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  q_in,
  input  logic          q_valid,
  output logic [CW-1:0] period,
  output logic          busy,
  output logic          done,
  output logic          stuck,
  output logic          ovf,
  output logic          timeout
);

  chk_state_t    state, state_n;
  logic [N-1:0]  ref_state;
  logic [CW-1:0] cnt, nxt;
  logic          cnt_at_max, cnt_clr, cnt_inc;
  logic          start_ok, sample_zero, sample_match, nxt_max;
  logic          capture_ref, to_done, to_fault, stall_hit;
  logic          stuck_q, ovf_q, timeout_q;

  // q_in is only looked at when q_valid is high, so X during stalls is masked.
  assign start_ok     = start && (state inside {IDLE, DONE, FAULT});
  assign sample_zero  = q_valid && (q_in == '0);
  assign sample_match = q_valid && (q_in == ref_state);
  assign nxt          = cnt + 1'b1;
  assign nxt_max      = (nxt == '1) || cnt_at_max;
  assign capture_ref  = (state == ARM) && q_valid && !sample_zero;
  assign cnt_clr      = start_ok || capture_ref;

  sat_counter #(.W(CW)) u_period_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (cnt),
    .at_max (cnt_at_max)
  );

`ifdef LFSR_CHK_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_cnt;
  logic          stall_at_max, stall_inc;

  assign stall_inc = (state inside {ARM, COUNT}) && !q_valid;
  // Fires on the TIMEOUT-th consecutive empty cycle.
  assign stall_hit = stall_inc && ((stall_cnt == SW'(TIMEOUT - 1)) || stall_at_max);

  sat_counter #(.W(SW)) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (!stall_inc),
    .inc    (stall_inc),
    .cnt    (stall_cnt),
    .at_max (stall_at_max)
  );
`else
  assign stall_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n  = state;
    cnt_inc  = 1'b0;
    to_done  = 1'b0;
    to_fault = 1'b0;
    case (state)
      IDLE, DONE, FAULT: if (start) state_n = ARM;
      ARM: begin
        if (sample_zero)  to_fault = 1'b1;
        else if (q_valid) state_n  = COUNT;
        else if (stall_hit) to_fault = 1'b1;
      end
      COUNT: begin
        // Zero check precedes the compare: an all-zero reference is never valid.
        if (sample_zero)                to_fault = 1'b1;
        else if (sample_match)          to_done  = 1'b1;
        else if (q_valid && nxt_max)    to_done  = 1'b1;
        else if (q_valid)               cnt_inc  = 1'b1;
        else if (stall_hit)             to_fault = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (to_done)  state_n = DONE;
    if (to_fault) state_n = FAULT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_state <= '0;
      period    <= '0;
      stuck_q   <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (start_ok) begin
        period    <= '0;
        stuck_q   <= 1'b0;
        ovf_q     <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (capture_ref) ref_state <= q_in;
      if (to_fault) begin
        stuck_q   <= sample_zero;
        timeout_q <= stall_hit;
      end
      if (to_done) begin
        period <= sample_match ? nxt : '1;
        ovf_q  <= !sample_match;
      end
    end
  end

  assign busy    = (state == ARM) || (state == COUNT);
  assign done    = (state == DONE);
  assign stuck   = stuck_q;
  assign ovf     = ovf_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Scoreboard bench for lfsr_period_checker (N=4, CW=3); honours LFSR_CHK_TIMEOUT_EN.
module tb_lfsr_period_checker;

  localparam int N  = 4;
  localparam int CW = 3;
`ifdef LFSR_CHK_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif
  localparam int MAXC = (1 << CW) - 1;

  typedef enum int {K_DONE, K_OVF, K_STUCK, K_TIMEOUT, K_NONE} kind_t;
  typedef struct {
    kind_t kind;
    int    period;
    int    samples;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  q_in = '0;
  logic          q_valid = 1'b0;
  logic [CW-1:0] period;
  logic          busy, done, stuck, ovf, timeout;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lfsr_period_checker #(.N(N), .CW(CW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q_in    (q_in),
    .q_valid (q_valid),
    .period  (period),
    .busy    (busy),
    .done    (done),
    .stuck   (stuck),
    .ovf     (ovf),
    .timeout (timeout)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: walk the sample list applying the measurement rules directly.
  function automatic exp_t model(input int s[$]);
    exp_t e;
    e = '{K_NONE, 0, 0};
    if (s[0] == 0) return '{K_STUCK, 0, 1};
    for (int k = 1; k < s.size(); k++) begin
      if (s[k] == 0)    return '{K_STUCK, 0, k + 1};
      if (s[k] == s[0]) return '{K_DONE, k, k + 1};
      if (k == MAXC)    return '{K_OVF, MAXC, k + 1};
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int s[$], input int gaps[$], input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        q_valid = 1'b0;
        q_in    = 'x;
        start   = stray && ($urandom_range(0, 2) == 0);
        tick();
      end
      start   = 1'b0;
      q_valid = 1'b1;
      q_in    = N'(s[i]);
      tick();
    end
    q_valid = 1'b0;
    q_in    = 'x;
  endtask

  task automatic finish_meas(input exp_t e);
    int budget = 0;
    while (sb.size() > 0 && budget < 40) begin
      tick();
      budget++;
    end
    if (sb.size() > 0) begin
      check("result_wait_expired", 32'(sb.size()), 0);
      sb.delete();
    end
    repeat (3) tick();
    check("hold_done", done, (e.kind == K_DONE || e.kind == K_OVF));
    check("hold_stuck", stuck, (e.kind == K_STUCK));
    check("hold_period", period, (e.kind == K_DONE || e.kind == K_OVF) ? e.period : 0);
    check("hold_busy", busy, 0);
  endtask

  task automatic run_meas(input int s[$], input int gaps[$], input bit stray);
    exp_t e;
    e = model(s);
    sb.push_back(e);
    start_meas();
    feed(s, gaps, e.samples, stray);
    finish_meas(e);
  endtask

  // Monitor: counts consumed samples and scores each completion against the queue.
  int   mon_samples = 0;
  bit   consume_flag = 0, busy_prev = 0, term_prev = 0;
  initial begin : monitor
    exp_t e;
    bit   term;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_samples  = 0;
        consume_flag = 0;
        busy_prev    = 0;
        term_prev    = 0;
      end else begin
        if (consume_flag) mon_samples++;
        if (busy && !busy_prev) mon_samples = 0;
        term = (done === 1'b1) || (stuck === 1'b1) || (timeout === 1'b1);
        if (term && !term_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            check("sb_done", done, (e.kind == K_DONE || e.kind == K_OVF));
            check("sb_ovf", ovf, (e.kind == K_OVF));
            check("sb_stuck", stuck, (e.kind == K_STUCK));
            check("sb_timeout", timeout, (e.kind == K_TIMEOUT));
            check("sb_period", period, (e.kind == K_DONE || e.kind == K_OVF) ? e.period : 0);
            check("sb_busy", busy, 0);
            check("sb_samples", mon_samples, e.samples);
            check("sb_latency", consume_flag, (e.kind != K_TIMEOUT));
          end
        end
        term_prev    = term;
        busy_prev    = (busy === 1'b1);
        consume_flag = (busy === 1'b1) && (q_valid === 1'b1);
      end
    end
  end

  initial begin : driver
    int s[$];
    int gaps[$];
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stuck", stuck, 0);
    check("rst_ovf", ovf, 0);
    check("rst_timeout", timeout, 0);
    check("rst_period", period, 0);
    tick();
    reset = 1'b1;
    tick();

    // Basic recurrence, then the same run with a 3-cycle stall before the third sample.
    run_meas('{1, 2, 4, 8, 1}, '{0, 0, 0, 0, 0}, 0);
    run_meas('{1, 2, 4, 8, 1}, '{0, 0, 3, 0, 0}, 0);

    // All-zero first sample faults; the next start clears stuck.
    run_meas('{0}, '{0}, 0);
    check("fault_no_done", done, 0);
    run_meas('{3, 6, 3}, '{0, 0, 0}, 0);

    // Asynchronous reset while DONE, then while COUNT.
    reset = 1'b0;
    #1;
    check("arst_done_period", period, 0);
    check("arst_done_done", done, 0);
    tick();
    reset = 1'b1;
    tick();
    start_meas();
    feed('{1, 2}, '{0, 0}, 2, 0);
    check("mid_busy_before", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_count_busy", busy, 0);
    check("arst_count_period", period, 0);
    check("arst_count_done", done, 0);
    tick();
    reset = 1'b1;
    tick();
    run_meas('{5, 7, 9, 5}, '{0, 1, 0, 0}, 0);

    // Counter saturation without recurrence.
    run_meas('{1, 2, 3, 4, 5, 6, 7, 8, 9}, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 0);

`ifdef LFSR_CHK_TIMEOUT_EN
    // A gap of TIMEOUT-1 is tolerated; a gap of TIMEOUT faults.
    sb.push_back('{K_TIMEOUT, 0, 1});
    start_meas();
    feed('{2}, '{TO - 1}, 1, 0);
    check("gap_short_busy", busy, 1);
    repeat (TO - 1) tick();
    check("gap_long_pending", timeout, 0);
    finish_meas('{K_TIMEOUT, 0, 1});
    check("timeout_flag", timeout, 1);
`else
    // Without the stall fault a long stall simply waits; then period=1 boundary.
    sb.push_back('{K_DONE, 1, 2});
    start_meas();
    for (int c = 0; c < 4; c++) begin
      repeat (25) tick();
      check("stall_busy", busy, 1);
      check("stall_timeout", timeout, 0);
    end
    feed('{2, 2}, '{0, 0}, 2, 0);
    finish_meas('{K_DONE, 1, 2});
`endif

    // Randomized runs with stalls, X on idle q_in and stray start pulses.
    for (int r = 0; r < 40; r++) begin
      int refv;
      refv = $urandom_range(1, 15);
      if ($urandom_range(0, 15) == 0) refv = 0;
      s.delete();
      gaps.delete();
      s.push_back(refv);
      for (int k = 1; k < 10; k++) begin
        int pick;
        pick = $urandom_range(0, 19);
        if (pick == 0)     s.push_back(0);
        else if (pick < 5) s.push_back(refv);
        else               s.push_back($urandom_range(1, 15));
      end
      for (int k = 0; k < 10; k++) gaps.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      run_meas(s, gaps, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
